uart_tx_callee: RTL and testbench

- Callee-side (responder) block for the compiler's start/idle/valid call protocol. A caller function module issues one call per byte; the block serialises that byte as a UART 8N1 frame on `tx`.
- Counterpart to the caller-side glue in top-level designs: the caller drives `__p_c` and `__start`, and this block answers with `__idle` and `__valid`.
- Instantiated next to the other callees in a top level. Its `tx` output goes straight to a board pin.

---
 rtl/uart_tx_callee.sv | 123 ++++++++++++
 tb/tb_uart_tx_callee.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_callee.sv
// Callee for the start/idle/valid call protocol.
// Sends one byte per call as a UART 8N1 frame on tx and pulses __valid after the stop bit.
module uart_tx_callee #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       __clk,
  input  logic       __reset,
  input  logic [7:0] __p_c,
  input  logic       __start,
  output logic       __idle,
  output logic       __valid,
  output logic       tx
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_callee: CLKS_PER_BIT must be 2 or greater");
    end
  endgenerate

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic            tx_reg, tx_next;
  logic            idle_reg, idle_next;
  logic            valid_reg, valid_next;
  logic            baud_wrap;

  assign baud_wrap = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    tx_next    = tx_reg;
    idle_next  = idle_reg;
    valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        idle_next = 1'b1;
        baud_next = '0;
        bit_next  = 3'd0;
        if (__start && idle_reg) begin
          state_next = START;
          shreg_next = __p_c;
          tx_next    = 1'b0;
          idle_next  = 1'b0;
        end
      end
      START: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_ONE;
        if (baud_wrap) begin
          state_next = DATA;
          tx_next    = shreg_reg[0];
        end
      end
      DATA: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_ONE;
        if (baud_wrap) begin
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            bit_next   = 3'd0;
            tx_next    = 1'b1;
          end else begin
            // next data bit is already sitting at shreg[1] before the shift lands
            bit_next   = bit_reg + 3'd1;
            shreg_next = {1'b0, shreg_reg[7:1]};
            tx_next    = shreg_reg[1];
          end
        end
      end
      STOP: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_ONE;
        if (baud_wrap) begin
          state_next = IDLE;
          idle_next  = 1'b1;
          valid_next = 1'b1;
          tx_next    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idle_next  = 1'b1;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge __clk) begin
    if (__reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= 3'd0;
      shreg_reg <= 8'd0;
      tx_reg    <= 1'b1;
      idle_reg  <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      tx_reg    <= tx_next;
      idle_reg  <= idle_next;
      valid_reg <= valid_next;
    end
  end

  assign tx      = tx_reg;
  assign __idle  = idle_reg;
  assign __valid = valid_reg;

endmodule

// File: tb/tb_uart_tx_callee.sv
// Bench for uart_tx_callee: one instance at 4 clocks/bit, one at 2 clocks/bit,
// checked every cycle against a frame-offset model plus literal frame/latency expectations.
module tb_uart_tx_callee;

  logic       clk = 1'b0;
  logic [1:0] reset_v = 2'b11;
  logic [1:0] start_v = 2'b00;
  logic [7:0] p_c_v [2];
  logic [1:0] idle_v, valid_v, tx_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_callee #(.CLKS_PER_BIT(4)) u_dut4 (
    .__clk(clk), .__reset(reset_v[0]), .__p_c(p_c_v[0]), .__start(start_v[0]),
    .__idle(idle_v[0]), .__valid(valid_v[0]), .tx(tx_v[0])
  );

  uart_tx_callee #(.CLKS_PER_BIT(2)) u_dut2 (
    .__clk(clk), .__reset(reset_v[1]), .__p_c(p_c_v[1]), .__start(start_v[1]),
    .__idle(idle_v[1]), .__valid(valid_v[1]), .tx(tx_v[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Line level at offset d (1-based cycle after accept) within a frame.
  function automatic logic frame_bit(input logic [7:0] b, input int d, input int cpb);
    int s;
    s = (d - 1) / cpb;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  int         cyc = 0;
  bit         chk_en [2];
  bit         m_busy [2];
  int         m_t [2];
  logic [7:0] m_byte [2];
  int         m_acc_edge [2];
  logic       m_idle [2];
  logic       m_valid [2];
  logic       m_tx [2];

  // Model: advances once per clock edge, using the inputs that were stable before the edge.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit acc;
      acc = !reset_v[i] && start_v[i] && (m_idle[i] === 1'b1);
      if (reset_v[i]) begin
        m_busy[i] = 0; m_idle[i] = 1'b1; m_tx[i] = 1'b1; m_valid[i] = 1'b0; chk_en[i] = 1;
      end else if (acc) begin
        m_busy[i] = 1; m_t[i] = 1; m_byte[i] = p_c_v[i]; m_acc_edge[i] = cyc;
        m_idle[i] = 1'b0; m_valid[i] = 1'b0; m_tx[i] = frame_bit(p_c_v[i], 1, cpb_of(i));
      end else if (m_busy[i]) begin
        m_t[i]++;
        if (m_t[i] <= 10 * cpb_of(i)) begin
          m_tx[i] = frame_bit(m_byte[i], m_t[i], cpb_of(i)); m_idle[i] = 1'b0; m_valid[i] = 1'b0;
        end else begin
          m_busy[i] = 0; m_idle[i] = 1'b1; m_valid[i] = 1'b1; m_tx[i] = 1'b1;
        end
      end else begin
        m_idle[i] = 1'b1; m_valid[i] = 1'b0; m_tx[i] = 1'b1;
      end
    end
  end

  int   valid_count [2];
  int   last_valid [2];
  int   prev_valid [2];
  int   idle_low0 = 0;
  logic cap [2][10];

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chk_en[i]) begin
        check($sformatf("tx[%0d]", i), {31'd0, tx_v[i]}, {31'd0, m_tx[i]});
        check($sformatf("idle[%0d]", i), {31'd0, idle_v[i]}, {31'd0, m_idle[i]});
        check($sformatf("valid[%0d]", i), {31'd0, valid_v[i]}, {31'd0, m_valid[i]});
        if (valid_v[i] === 1'b1) begin
          valid_count[i]++;
          prev_valid[i] = last_valid[i];
          last_valid[i] = cyc + 1;
        end
        if (m_busy[i] && ((m_t[i] - 1) % cpb_of(i) == cpb_of(i) / 2))
          cap[i][(m_t[i] - 1) / cpb_of(i)] = tx_v[i];
      end
    end
    if (chk_en[0] && idle_v[0] === 1'b0) idle_low0++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_cap(input int i);
    for (int s = 0; s < 10; s++) cap[i][s] = 1'bx;
  endtask

  task automatic send(input int i, input logic [7:0] b);
    clear_cap(i);
    @(posedge clk); #2;
    p_c_v[i] = b; start_v[i] = 1'b1;
    @(posedge clk); #2;
    start_v[i] = 1'b0; p_c_v[i] = ~b;
  endtask

  task automatic check_frame(input int i, input string name, input logic [9:0] expv);
    for (int s = 0; s < 10; s++)
      check($sformatf("%s slot%0d", name, s), {31'd0, cap[i][s]}, {31'd0, expv[s]});
  endtask

  int vc;

  initial begin
    p_c_v[0] = 8'h00; p_c_v[1] = 8'h00;

    // reset held 3 cycles, then 20 idle cycles
    cycles(3); #2;
    reset_v = 2'b00;
    cycles(20);
    @(negedge clk);
    check("idle tx", {31'd0, tx_v[0]}, 32'd1);
    check("idle idle", {31'd0, idle_v[0]}, 32'd1);
    check("idle valid count", valid_count[0], 32'd0);
    $display("reset/idle: %0d valid pulses", valid_count[0]);

    // single byte 0xA5
    idle_low0 = 0; vc = valid_count[0];
    send(0, 8'hA5);
    cycles(45);
    check("a5 latency", last_valid[0] - m_acc_edge[0], 32'd41);
    check("a5 valid count", valid_count[0] - vc, 32'd1);
    check("a5 idle low cycles", idle_low0, 32'd40);
    check_frame(0, "a5", 10'b1_1010_0101_0);
    $display("byte a5: latency %0d", last_valid[0] - m_acc_edge[0]);

    // back-to-back 0x00 then 0xFF, start held high
    vc = valid_count[0];
    @(posedge clk); #2;
    p_c_v[0] = 8'h00; start_v[0] = 1'b1;
    @(posedge clk); #2;
    p_c_v[0] = 8'hFF;
    repeat (41) @(posedge clk);
    #2;
    start_v[0] = 1'b0; p_c_v[0] = 8'h12;
    cycles(45);
    check("b2b valid count", valid_count[0] - vc, 32'd2);
    check("b2b valid spacing", last_valid[0] - prev_valid[0], 32'd41);
    check("b2b second accept", m_acc_edge[0], prev_valid[0]);
    $display("back-to-back 00/ff: spacing %0d", last_valid[0] - prev_valid[0]);

    // start while busy is ignored
    vc = valid_count[0];
    send(0, 8'h55);
    cycles(18); #2;
    p_c_v[0] = 8'h0F; start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0;
    cycles(30);
    check("busy valid count", valid_count[0] - vc, 32'd1);
    check_frame(0, "busy 55", 10'b1_0101_0101_0);
    $display("byte 55 with busy start: %0d valid", valid_count[0] - vc);

    // reset during DATA bit 3, with start asserted during reset
    vc = valid_count[0];
    send(0, 8'h99);
    cycles(16); #2;
    reset_v[0] = 1'b1; start_v[0] = 1'b1; p_c_v[0] = 8'hE7;
    @(posedge clk); #2;
    reset_v[0] = 1'b0; start_v[0] = 1'b0;
    @(negedge clk);
    check("abort tx", {31'd0, tx_v[0]}, 32'd1);
    check("abort idle", {31'd0, idle_v[0]}, 32'd1);
    cycles(50);
    check("abort valid count", valid_count[0] - vc, 32'd0);
    send(0, 8'h3C);
    cycles(45);
    check("3c latency", last_valid[0] - m_acc_edge[0], 32'd41);
    check("3c valid count", valid_count[0] - vc, 32'd1);
    check_frame(0, "3c", 10'b1_0011_1100_0);
    $display("abort then byte 3c: latency %0d", last_valid[0] - m_acc_edge[0]);

    // two clocks per bit
    vc = valid_count[1];
    send(1, 8'h81);
    cycles(25);
    check("cpb2 latency", last_valid[1] - m_acc_edge[1], 32'd21);
    check("cpb2 valid count", valid_count[1] - vc, 32'd1);
    check_frame(1, "cpb2 81", 10'b1_1000_0001_0);
    $display("cpb2 byte 81: latency %0d", last_valid[1] - m_acc_edge[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
